// File: rtl/redmule_pkg.sv
// Shared RedMulE constants and helpers for the narrow TCDM lane split.
// Lane slices are sized from the wide data width and the number of lanes.
package redmule_pkg;

  localparam int unsigned DATA_W  = 256;
  localparam int unsigned MemDw   = 32;
  localparam int unsigned LANE_DW = DATA_W / (DATA_W / MemDw);
  localparam int unsigned LANE_BE = LANE_DW / 8;

  // The request FSM state is implied by the granted mask; this names it.
  typedef enum logic {
    REQ_IDLE,
    REQ_PARTIAL
  } req_state_e;

  // Byte distance between consecutive lane addresses.
  function automatic int unsigned lane_stride(input int unsigned dw, input int unsigned mp);
    return dw / (mp * 8);
  endfunction

endpackage

// File: rtl/redmule_tcdm_lane_fifo.sv
// Per-lane response buffer: holds narrow r_data until every lane has answered.
// Overflow is excluded by the credit scheme in the parent block.
module redmule_tcdm_lane_fifo
  import redmule_pkg::*;
#(
  parameter int unsigned W     = LANE_DW,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  assign data_o = mem[rd_ptr];
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/redmule_tcdm_lane_sync.sv
// Splits one wide TCDM request into MP narrow lanes, keeping each lane's request
// up until it is granted, and re-joins the per-lane responses into one wide beat.
module redmule_tcdm_lane_sync
  import redmule_pkg::*;
#(
  parameter int unsigned DW         = 256,
  parameter int unsigned MP         = DW / redmule_pkg::MemDw,
  parameter int unsigned AW         = 32,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          up_req_i,
  output logic                          up_gnt_o,
  input  logic [AW-1:0]                 up_add_i,
  input  logic                          up_wen_i,
  input  logic [DW/8-1:0]               up_be_i,
  input  logic [DW-1:0]                 up_data_i,
  output logic [DW-1:0]                 up_r_data_o,
  output logic                          up_r_valid_o,
  output logic [MP-1:0]                 lane_req_o,
  input  logic [MP-1:0]                 lane_gnt_i,
  output logic [MP-1:0][AW-1:0]         lane_add_o,
  output logic [MP-1:0]                 lane_wen_o,
  output logic [MP-1:0][DW/(MP*8)-1:0]  lane_be_o,
  output logic [MP-1:0][DW/MP-1:0]      lane_data_o,
  input  logic [MP-1:0][DW/MP-1:0]      lane_r_data_i,
  input  logic [MP-1:0]                 lane_r_valid_i
);

  localparam int unsigned L_DW   = DW / MP;
  localparam int unsigned L_BE   = L_DW / 8;
  localparam int unsigned STRIDE = lane_stride(DW, MP);
  localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(RESP_DEPTH);

  req_state_e        state;
  logic [MP-1:0]     mask, mask_next, lane_hit;
  logic [CNT_W-1:0]  outstanding;
  logic              blocked, first_grant, pop;
  logic [MP-1:0]     empty, full;
  logic [L_DW-1:0]   head [MP];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask        <= '0;
      outstanding <= '0;
    end else begin
      mask <= mask_next;
      case ({first_grant, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Credit check only gates the start of a transaction; once any lane is
  // granted the transaction is committed. Reset also masks the request outputs.
  always_comb begin
    state       = (mask == '0) ? REQ_IDLE : REQ_PARTIAL;
    blocked     = (state == REQ_IDLE) && (outstanding >= MAX_OUT);
    lane_req_o  = '0;
    up_gnt_o    = 1'b0;
    if (up_req_i && !blocked && !rst_i) begin
      lane_req_o = ~mask;
      up_gnt_o   = &(mask | lane_gnt_i);
    end
    lane_hit    = lane_req_o & lane_gnt_i;
    first_grant = (state == REQ_IDLE) && (|lane_hit);
    mask_next   = up_gnt_o ? '0 : (mask | lane_hit);
  end

  assign pop          = ~|empty;
  assign up_r_valid_o = pop;

  for (genvar i = 0; i < MP; i++) begin : g_lane
    assign lane_add_o[i]  = up_add_i + AW'(i * STRIDE);
    assign lane_wen_o[i]  = up_wen_i;
    assign lane_be_o[i]   = up_be_i[i*L_BE +: L_BE];
    assign lane_data_o[i] = up_data_i[i*L_DW +: L_DW];

    redmule_tcdm_lane_fifo #(
      .W     (L_DW),
      .DEPTH (RESP_DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push   (lane_r_valid_i[i]),
      .pop    (pop),
      .data_i (lane_r_data_i[i]),
      .data_o (head[i]),
      .empty  (empty[i]),
      .full   (full[i])
    );

    assign up_r_data_o[i*L_DW +: L_DW] = up_r_valid_o ? head[i] : '0;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(lane_r_valid_i[i] && full[i] && !pop));
  end

  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (mask != '0) |-> up_req_i);

  a_add_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (up_req_i && !up_gnt_o) |=> (up_req_i && $stable(up_add_i)));

endmodule

// File: doc/redmule_tcdm_lane_sync.md
Name: redmule_tcdm_lane_sync

Overview:
- Sits between the RedMulE wide HCI TCDM master and the MP narrow interconnect ports.
- Replaces the plain lane fan-out whose grant and response are the AND of all lanes.
- Keeps each lane's request up until that lane alone is granted. Buffers per-lane responses that arrive on different cycles.
- Presents one wide grant and one wide r_valid upstream only when every lane has completed.

Parameters:
- DW, 256, wide data width in bits (redmule_pkg::DATA_W).
- MP, DW/redmule_pkg::MemDw (default 8), number of narrow lanes; DW must be divisible by MP*8.
- AW, 32, address width.
- RESP_DEPTH, 2, per-lane response FIFO depth and maximum wide transactions in flight; minimum 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- up_req_i  in  1  wide request; held stable with its payload until up_gnt_o
- up_gnt_o  out  1  wide grant
- up_add_i  in  AW  byte address of lane 0
- up_wen_i  in  1  1 = read, 0 = write
- up_be_i  in  DW/8  byte enables
- up_data_i  in  DW  write data
- up_r_data_o  out  DW  read data; lane i occupies bits [(i+1)*DW/MP-1 : i*DW/MP]
- up_r_valid_o  out  1  wide response valid; no backpressure
- lane_req_o  out  MP  per-lane request
- lane_gnt_i  in  MP  per-lane grant
- lane_add_o  out  MP x AW  up_add_i + i*DW/(MP*8)
- lane_wen_o  out  MP  copy of up_wen_i
- lane_be_o  out  MP x DW/(MP*8)  slice i of up_be_i
- lane_data_o  out  MP x DW/MP  slice i of up_data_i
- lane_r_data_i  in  MP x DW/MP  per-lane response data
- lane_r_valid_i  in  MP  per-lane response valid; every granted request, read or write, returns exactly one

Behaviour:
- Reset state: granted mask = 0, outstanding = 0, all FIFOs empty. Consequently up_gnt_o, up_r_valid_o and lane_req_o are 0 and up_r_data_o = 0. Reset asserted mid-transaction drops all of these immediately and discards partial grants and buffered data.
- Request FSM (state encoded by the granted mask):
  - IDLE (mask = 0): a new transaction may start only if outstanding < RESP_DEPTH. Otherwise lane_req_o = 0 (blocked).
  - PARTIAL (mask != 0): the transaction is committed, so the credit check no longer applies.
- Lane request and grant:
  - lane_req_o[i] = up_req_i & ~mask[i] & ~blocked, combinational.
  - up_gnt_o = up_req_i & ~blocked & &(mask | lane_gnt_i), combinational; it pulses for exactly one cycle per transaction.
  - At the clock edge, mask <= up_gnt_o ? 0 : mask | (lane_req_o & lane_gnt_i).
- Outstanding counter (width clog2(RESP_DEPTH+1)):
  - Increments on the first lane grant of a transaction (mask = 0 and any lane_req_o & lane_gnt_i).
  - Decrements on a wide pop; a same-cycle increment and decrement leaves it unchanged.
  - A pop in the same cycle does not unblock: the credit check uses the registered count.
- Lane response path:
  - lane_r_valid_i[i] pushes lane_r_data_i[i] into FIFO i at the edge.
  - Overflow is impossible by the credit rule; a simulation assertion must check it.
- Wide response:
  - Pop when all MP FIFOs are non-empty.
  - up_r_valid_o = &(~empty); up_r_data_o = concatenated FIFO heads, zero when not valid.
  - Latency is one cycle after the last lane's r_valid; there is no bypass path.
  - At most one wide pop per cycle; back-to-back pops are allowed.
- Zero-latency case: all lanes granted in the same cycle as up_req_i rise gives up_gnt_o in that same cycle.
- Protocol assertions: up_req_i withdrawn while the mask is nonzero is illegal and must be asserted against. up_add_i must be stable while up_req_i=1 & ~up_gnt_o.

Decomposition:
- redmule_pkg holds:
  - the lane-slice width constant LANE_DW = DW/MP
  - the LANE_BE = LANE_DW/8 constant
  - the lane stride-in-bytes function
- One sub-module, redmule_tcdm_lane_fifo:
  - LANE_DW-wide, RESP_DEPTH deep
  - ports: push, pop, data_i, data_o, empty, full
  - asynchronous active-high reset
  - instantiated MP times

Test Plan:
1. All lane_gnt_i = 8'hFF in the cycle of a read to 0x1000 → up_gnt_o in that same cycle; lane_add_o = 0x1000, 0x1004, …, 0x101C; all lanes r_valid the next cycle → up_r_valid_o one cycle later with data 32'hA0..A7 in lanes 0..7.
2. Staggered grants (lanes 0-3 in cycle 0, lanes 4-7 in cycle 2) → lanes 0-3 drop their requests in cycle 1, up_gnt_o only in cycle 2, exactly one pulse.
3. Responses skewed (lane 7 arrives 3 cycles after lane 0) → up_r_valid_o exactly one cycle after lane 7's r_valid, data correctly aligned, a single pulse.
4. RESP_DEPTH=2, three back-to-back reads with lane responses withheld → third transaction gets lane_req_o = 0 until the first wide pop; all three responses are delivered in order.
5. rst_i asserted with mask = 8'h0F and one FIFO entry buffered → all outputs 0 asynchronously; after release, a fresh transaction completes normally with no stale response.
6. Write (up_wen_i=0, be=all ones) → lane_be_o and lane_data_o slices are correct; the write r_valids are consumed as one wide r_valid.
